// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, receive end of the serial link paired with uart_tx.
// The line is oversampled at CLKS_PER_BIT clocks per bit. The start bit is
// validated at its mid-point and every later bit is sampled one full bit period
// after the previous sample, so each sample lands near the middle of its bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (4..65535), default 521
// Ports:
//   rx_clk        receive clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   rx_in         asynchronous serial input, idles high
//   rx_out        last correctly received byte, held until the next good frame
//   rx_valid      one-cycle pulse, rx_out has just been updated
//   rx_frame_err  one-cycle pulse, stop bit sampled low and the frame discarded
//   rx_busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 521
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_out,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA_BURST,
    STOP
  } state_t;

  state_t state, state_nx;

  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_count, count_nx;
  logic [2:0]    bitpos, bitpos_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    out_nx;
  logic          valid_nx, err_nx;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  // Resetting all three to the idle level means reset never fakes an edge.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      rx_count     <= '0;
      bitpos       <= '0;
      shift        <= '0;
      rx_out       <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_count     <= count_nx;
      bitpos       <= bitpos_nx;
      shift        <= shift_nx;
      rx_out       <= out_nx;
      rx_valid     <= valid_nx;
      rx_frame_err <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = rx_count;
    bitpos_nx = bitpos;
    shift_nx  = shift;
    out_nx    = rx_out;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;

    case (state)
      IDLE: begin
        count_nx  = '0;
        bitpos_nx = '0;
        // Edge-triggered start: a line held low (break) cannot re-trigger.
        if (rx_prev && !rx_sync) begin
          state_nx = START;
        end
      end

      START: begin
        if (rx_count == HALF) begin
          count_nx = '0;
          // Line back high at mid-start-bit means it was a glitch.
          if (!rx_sync) begin
            state_nx = DATA_BURST;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          count_nx = rx_count + CW'(1);
        end
      end

      DATA_BURST: begin
        if (rx_count == LAST) begin
          count_nx         = '0;
          shift_nx[bitpos] = rx_sync;
          if (bitpos == 3'd7) begin
            bitpos_nx = '0;
            state_nx  = STOP;
          end else begin
            bitpos_nx = bitpos + 3'd1;
          end
        end else begin
          count_nx = rx_count + CW'(1);
        end
      end

      STOP: begin
        if (rx_count == LAST) begin
          count_nx = '0;
          state_nx = IDLE;
          if (rx_sync) begin
            out_nx   = shift;
            valid_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end else begin
          count_nx = rx_count + CW'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: one instance at C=16 for the directed
// scenarios, one at the default C=521 fed by a bit-serial transmitter model.
module tb_uart_rx;

  localparam int unsigned C  = 16;
  localparam int unsigned H  = (C - 1) / 2;
  localparam int unsigned C2 = 521;
  localparam int unsigned H2 = (C2 - 1) / 2;

  logic       rx_clk = 1'b0;
  logic       rst    = 1'b1;
  logic       rx_in  = 1'b1;
  logic [7:0] rx_out;
  logic       rx_valid, rx_frame_err, rx_busy;

  logic       rx_in2 = 1'b1;
  logic [7:0] rx_out2;
  logic       rx_valid2, rx_frame_err2, rx_busy2;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .rx_out      (rx_out),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  uart_rx dut2 (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx_in       (rx_in2),
    .rx_out      (rx_out2),
    .rx_valid    (rx_valid2),
    .rx_frame_err(rx_frame_err2),
    .rx_busy     (rx_busy2)
  );

  always #5 rx_clk = ~rx_clk;

  int unsigned cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Strobe log, sampled mid-cycle.
  int unsigned v_cyc[$];
  logic [7:0]  v_dat[$];
  int unsigned e_cyc[$];
  int unsigned v2_cyc[$];
  logic [7:0]  v2_dat[$];
  int unsigned e2_cnt = 0;
  int unsigned overlap_cnt = 0;
  int unsigned consec_cnt = 0;
  logic prev_v = 1'b0, prev_e = 1'b0;

  always @(negedge rx_clk) begin
    if (rx_valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(rx_out);
    end
    if (rx_frame_err === 1'b1) e_cyc.push_back(cyc);
    if (rx_valid2 === 1'b1) begin
      v2_cyc.push_back(cyc);
      v2_dat.push_back(rx_out2);
    end
    if (rx_frame_err2 === 1'b1) e2_cnt <= e2_cnt + 1;
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if ((rx_valid === 1'b1 && prev_v) || (rx_frame_err === 1'b1 && prev_e))
      consec_cnt <= consec_cnt + 1;
    prev_v <= (rx_valid === 1'b1);
    prev_e <= (rx_frame_err === 1'b1);
  end

  task automatic clear_logs();
    v_cyc.delete();
    v_dat.delete();
    e_cyc.delete();
    v2_cyc.delete();
    v2_dat.delete();
  endtask

  // Drives one 8N1 frame on rx_in, each bit exactly C cycles long.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            output int unsigned start_cyc);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    start_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge rx_clk);
      #1;
      rx_in = frame[i];
      if (i == 0) start_cyc = cyc;
      repeat (C - 1) @(posedge rx_clk);
    end
  endtask

  // Transmitter model for the default-rate instance.
  task automatic uart_tx_model(input logic [7:0] data, output int unsigned start_cyc);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    start_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge rx_clk);
      #1;
      rx_in2 = frame[i];
      if (i == 0) start_cyc = cyc;
      repeat (C2 - 1) @(posedge rx_clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(posedge rx_clk);
      #1;
      rx_in = ~rx_in;
    end
    @(negedge rx_clk);
    n_checks++;
    if (rx_out !== 8'h00) begin n_fail++; $display("FAIL reset_rx_out: got %h, expected 00", rx_out); end
    n_checks++;
    if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got valid=%b err=%b, expected 0 0", rx_valid, rx_frame_err);
    end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", rx_busy); end
    n_checks++;
    if (rx_out2 !== 8'h00 || rx_busy2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut2: got out=%h busy=%b, expected 00 0", rx_out2, rx_busy2);
    end
    @(posedge rx_clk);
    #1;
    rst   = 1'b0;
    rx_in = 1'b1;
    clear_logs();
    repeat (20 * C) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 0 || e_cyc.size() != 0) begin
      n_fail++; $display("FAIL reset_quiet: got %0d valid %0d err pulses, expected 0 0", v_cyc.size(), e_cyc.size());
    end
  endtask

  task automatic test_single();
    int unsigned d;
    clear_logs();
    send_frame(8'hA5, 1'b1, d);
    repeat (4) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d valid pulses, expected 1", v_cyc.size());
    end else begin
      // Line low at d -> rx_sync low at d+2 (=E); strobe at E+2+H+9C.
      n_checks++;
      if (v_cyc[0] != d + 4 + H + 9 * C) begin
        n_fail++; $display("FAIL single_timing: got cycle %0d, expected %0d", v_cyc[0], d + 4 + H + 9 * C);
      end
      n_checks++;
      if (v_dat[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h, expected a5", v_dat[0]); end
    end
    n_checks++;
    if (e_cyc.size() != 0) begin n_fail++; $display("FAIL single_err: got %0d err pulses, expected 0", e_cyc.size()); end
    repeat (50) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (rx_out !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h, expected a5", rx_out); end
  endtask

  task automatic test_back_to_back();
    int unsigned d0, d1, d2;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    clear_logs();
    send_frame(8'h00, 1'b1, d0);
    send_frame(8'hFF, 1'b1, d1);
    send_frame(8'h3C, 1'b1, d2);
    repeat (4) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d valid pulses, expected 3", v_cyc.size());
    end else begin
      n_checks++;
      if (v_cyc[0] != d0 + 4 + H + 9 * C) begin
        n_fail++; $display("FAIL b2b_first_timing: got %0d, expected %0d", v_cyc[0], d0 + 4 + H + 9 * C);
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (v_dat[i] !== exp_b[i]) begin
          n_fail++; $display("FAIL b2b_data%0d: got %h, expected %h", i, v_dat[i], exp_b[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (v_cyc[i] - v_cyc[i-1] != 10 * C) begin
          n_fail++; $display("FAIL b2b_spacing%0d: got %0d, expected %0d", i, v_cyc[i] - v_cyc[i-1], 10 * C);
        end
      end
    end
    n_checks++;
    if (e_cyc.size() != 0) begin n_fail++; $display("FAIL b2b_err: got %0d err pulses, expected 0", e_cyc.size()); end
  endtask

  task automatic test_glitch();
    clear_logs();
    @(posedge rx_clk);
    #1;
    rx_in = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    rx_in = 1'b1;
    @(negedge rx_clk);                       // E+1
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b, expected 1", rx_busy); end
    repeat (H) @(posedge rx_clk);
    @(negedge rx_clk);                       // E+1+H, last busy cycle
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hold: got %b, expected 1", rx_busy); end
    @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b, expected 0", rx_busy); end
    repeat (20 * C) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 0 || e_cyc.size() != 0) begin
      n_fail++; $display("FAIL glitch_strobe: got %0d valid %0d err, expected 0 0", v_cyc.size(), e_cyc.size());
    end
    n_checks++;
    if (rx_out !== 8'h3C) begin n_fail++; $display("FAIL glitch_rx_out: got %h, expected 3c", rx_out); end
  endtask

  task automatic test_frame_err();
    int unsigned d;
    clear_logs();
    send_frame(8'h55, 1'b0, d);
    repeat (30 * C) @(posedge rx_clk);     // line stays low (break)
    @(negedge rx_clk);
    n_checks++;
    if (e_cyc.size() != 1) begin
      n_fail++; $display("FAIL ferr_count: got %0d err pulses, expected 1", e_cyc.size());
    end else begin
      n_checks++;
      if (e_cyc[0] != d + 4 + H + 9 * C) begin
        n_fail++; $display("FAIL ferr_timing: got %0d, expected %0d", e_cyc[0], d + 4 + H + 9 * C);
      end
    end
    n_checks++;
    if (v_cyc.size() != 0) begin n_fail++; $display("FAIL ferr_valid: got %0d valid pulses, expected 0", v_cyc.size()); end
    n_checks++;
    if (rx_out !== 8'h3C) begin n_fail++; $display("FAIL ferr_rx_out: got %h, expected 3c", rx_out); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_retrigger: got busy %b, expected 0", rx_busy); end
    @(posedge rx_clk);
    #1;
    rx_in = 1'b1;
    repeat (2 * C) @(posedge rx_clk);
    clear_logs();
    send_frame(8'h81, 1'b1, d);
    repeat (4) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 1 || e_cyc.size() != 0) begin
      n_fail++; $display("FAIL after_break_count: got %0d valid %0d err, expected 1 0", v_cyc.size(), e_cyc.size());
    end else begin
      n_checks++;
      if (v_dat[0] !== 8'h81 || v_cyc[0] != d + 4 + H + 9 * C) begin
        n_fail++; $display("FAIL after_break_data: got %h at %0d, expected 81 at %0d", v_dat[0], v_cyc[0], d + 4 + H + 9 * C);
      end
    end
  endtask

  task automatic test_mid_reset();
    int unsigned d;
    logic [9:0] frame;
    frame = {1'b1, 8'hC3, 1'b0};
    clear_logs();
    // Start bit and data bits 0..3, then 8 cycles into bit 4.
    for (int i = 0; i < 6; i++) begin
      @(posedge rx_clk);
      #1;
      rx_in = frame[i];
      repeat ((i == 5) ? 8 : C - 1) @(posedge rx_clk);
    end
    @(negedge rx_clk);
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, expected 1", rx_busy); end
    @(posedge rx_clk);
    #1;
    rst   = 1'b1;
    rx_in = 1'b1;                           // far-end transmitter is reset too
    @(posedge rx_clk);
    #1;
    rst = 1'b0;
    @(negedge rx_clk);
    n_checks++;
    if (rx_out !== 8'h00 || rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got out=%h busy=%b v=%b e=%b, expected 00 0 0 0",
                         rx_out, rx_busy, rx_valid, rx_frame_err);
    end
    repeat (12 * C) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 0 || e_cyc.size() != 0) begin
      n_fail++; $display("FAIL midrst_strobe: got %0d valid %0d err, expected 0 0", v_cyc.size(), e_cyc.size());
    end
    send_frame(8'h5A, 1'b1, d);
    repeat (4) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v_cyc.size() != 1) begin
      n_fail++; $display("FAIL midrst_next_count: got %0d valid pulses, expected 1", v_cyc.size());
    end else begin
      n_checks++;
      if (v_dat[0] !== 8'h5A) begin n_fail++; $display("FAIL midrst_next_data: got %h, expected 5a", v_dat[0]); end
    end
  endtask

  task automatic test_default_rate();
    int unsigned d;
    clear_logs();
    uart_tx_model(8'h7E, d);
    repeat (4) @(posedge rx_clk);
    @(negedge rx_clk);
    n_checks++;
    if (v2_cyc.size() != 1 || e2_cnt != 0) begin
      n_fail++; $display("FAIL c521_count: got %0d valid %0d err, expected 1 0", v2_cyc.size(), e2_cnt);
    end else begin
      n_checks++;
      if (v2_dat[0] !== 8'h7E) begin n_fail++; $display("FAIL c521_data: got %h, expected 7e", v2_dat[0]); end
      n_checks++;
      if (v2_cyc[0] != d + 4 + H2 + 9 * C2) begin
        n_fail++; $display("FAIL c521_timing: got %0d, expected %0d", v2_cyc[0], d + 4 + H2 + 9 * C2);
      end
    end
    n_checks++;
    if (rx_out2 !== 8'h7E) begin n_fail++; $display("FAIL c521_hold: got %h, expected 7e", rx_out2); end
  endtask

  task automatic test_strobe_rules();
    n_checks++;
    if (overlap_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d, expected 0", overlap_cnt); end
    n_checks++;
    if (consec_cnt != 0) begin n_fail++; $display("FAIL strobe_consecutive: got %0d, expected 0", consec_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_default_rate();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
